up_bus_bridge_fsm: RTL and testbench
====================================

# up_bus_bridge_fsm

Parametrised controller that moves one command packet from the 8-bit uP port onto the internal 32-bit bus. It then collects a configurable number of reply words from the addressed subsystem and returns a reply packet to the uP. Byte/word counters are internal, every handshake wait is guarded by a timeout, and a protocol error is reported to the uP. It sits between the uP byte-port datapath and the internal 32-bit bus, replacing the fixed-length interface sequencer.

## Interface
- IN_BYTES, 8: command packet length from uP, 1..255
- OUT_BYTES, 8: reply packet length to uP, 1..255
- RX_WORDS, 2: 32-bit words read from the slave per transaction, 1..15
- TIMEOUT_CYCLES, 50000: clk cycles allowed in any single wait state, ≥2
- clk  in  1  system clock
- reset  in  1  asynchronous active-low reset
- uP_start  in  1  uP requests a transaction; held high until uP_ack seen
- uP_soft_reset  in  1  decoded soft-reset command flag from packet datapath, sampled in S_DEC
- uP_ack  out  1  transaction complete
- uP_handshake_1  in  1  uP strobe
- uP_handshake_2  out  1  FPGA strobe to uP
- bus_handshake_1  out  1  master strobe on 32-bit bus
- bus_handshake_2  in  1  slave strobe on 32-bit bus
- read_uP_byte  out  1  one-cycle pulse: latch uP byte at byte_index
- write_uP_byte  out  1  one-cycle pulse: drive reply byte at byte_index
- byte_index  out  8  current byte position, 0-based
- read_bus_word  out  1  one-cycle pulse: latch bus word at word_index
- word_index  out  4  current reply word position, 0-based
- clear_uP_packet  out  1  one-cycle pulse: clear reply buffer (soft reset)
- busy  out  1  high in any state except S_IDLE
- error  out  1  sticky timeout flag; cleared on next uP_start rising into S_RX0
- error_code  out  2  0 none, 1 uP-receive/ping, 2 bus, 3 uP-transmit

## Operation
- Reset: state S_IDLE; all outputs 0; indices 0.
- S_IDLE: uP_start=1 → S_RX0 (clear byte_index, error, error_code). Else uP_handshake_1=1 → S_PING. uP_start has priority if both are high.
- S_PING: uP_handshake_2=1; uP_handshake_1=0 → S_IDLE.
- Receive: S_RX0 waits for uP_handshake_1=1 → S_RX1, which pulses read_uP_byte → S_RX2. S_RX2 asserts uP_handshake_2 and waits for uP_handshake_1=0, then goes to S_RX3. In S_RX3, if byte_index==IN_BYTES-1 → S_DEC; else byte_index++ → S_RX0.
- S_DEC: uP_soft_reset=1 → S_CLR (pulse clear_uP_packet) → S_TX0. Otherwise → S_WB0.
- Bus write: S_WB0 asserts bus_handshake_1 and waits for bus_handshake_2=1. S_WB1 deasserts bus_handshake_1 and waits for bus_handshake_2=0, then goes to S_RB0 with word_index=0.
- Bus read: S_RB0 asserts bus_handshake_1 and waits for bus_handshake_2=1. S_RB1 keeps bus_handshake_1 high and pulses read_bus_word. S_RB2 deasserts bus_handshake_1 and waits for bus_handshake_2=0. S_RB3: if word_index==RX_WORDS-1 → S_TX0 with byte_index=0; else word_index++ → S_RB0.
- Transmit: S_TX0 pulses write_uP_byte. S_TX1 asserts uP_handshake_2 and waits for uP_handshake_1=1. S_TX2 deasserts uP_handshake_2 and waits for uP_handshake_1=0. S_TX3: if byte_index==OUT_BYTES-1 → S_DONE; else byte_index++ → S_TX0.
- S_DONE: uP_ack=1; uP_start=0 → S_IDLE.
- S_ERR: all strobes low; waits for uP_start=0 and uP_handshake_1=0, then → S_IDLE. error stays 1.
- Index widths are fixed at 8/4 bits. Indices never wrap because terminal compares end each loop.

## Timing
- All outputs are registered-state Moore decodes; no output depends combinationally on inputs.
- Minimum per-byte receive: 4 cycles after strobes; per word: 4 cycles; per transmit byte: 4 cycles.
- read_uP_byte asserts exactly 1 cycle after uP_handshake_1 is sampled high. read_bus_word asserts in the cycle after bus_handshake_2 is sampled high.
- Timeout counter reloads to TIMEOUT_CYCLES on entry to each wait state and decrements each cycle while waiting. Expiry (count reaches 0) → S_ERR on the next edge, with error=1 and error_code set by phase.
- Reset asserted mid-transaction: immediate return to S_IDLE, all strobes low within the reset assertion.

## Configuration
- UP_BRIDGE_TIMEOUT_EN defined: timeout logic, S_ERR, error and error_code behave as above.
- Not defined: no timeout counter; waits are indefinite; S_ERR unreachable; error and error_code are tied to 0.

## Test plan
- Normal: IN_BYTES=8, RX_WORDS=2, OUT_BYTES=8, responsive uP/slave model → 8 read_uP_byte pulses (byte_index 0..7), 2 read_bus_word pulses, 8 write_uP_byte pulses, then uP_ack high until uP_start drops.
- Soft reset: uP_soft_reset=1 in S_DEC → one clear_uP_packet pulse, no bus_handshake_1 activity, 8 write_uP_byte pulses, then uP_ack.
- Ping: uP_handshake_1 pulsed high for 5 cycles with uP_start=0 → uP_handshake_2 high while in S_PING, FSM returns to S_IDLE, uP_ack stays 0.
- Bus timeout (macro on, TIMEOUT_CYCLES=20): slave never raises bus_handshake_2 → S_ERR about 21 cycles after S_WB0 entry, error=1, error_code=2, and the next uP_start clears error.
- Macro off, same stall for 1000 cycles → bus_handshake_1 stays high, error=0.
- Reset pulse during S_TX1 → all outputs 0 and busy=0 immediately; the following transaction completes normally.

Source files
------------

// File: rtl/up_bus_bridge_fsm.sv
// Purpose: moves one IN_BYTES command packet from the 8-bit uP port onto the 32-bit bus, reads RX_WORDS reply words, returns an OUT_BYTES reply packet.
// Latency: 4 cycles minimum per uP byte received, per bus word and per uP byte transmitted; all outputs are Moore decodes of registered state.
// Backpressure: every step waits on the peer's strobe; with UP_BRIDGE_TIMEOUT_EN defined, each wait is bounded by TIMEOUT_CYCLES and expiry lands in S_ERR.
module up_bus_bridge_fsm #(
    parameter int IN_BYTES       = 8,
    parameter int OUT_BYTES      = 8,
    parameter int RX_WORDS       = 2,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uP_start,
    input  logic       uP_soft_reset,
    output logic       uP_ack,
    input  logic       uP_handshake_1,
    output logic       uP_handshake_2,
    output logic       bus_handshake_1,
    input  logic       bus_handshake_2,
    output logic       read_uP_byte,
    output logic       write_uP_byte,
    output logic [7:0] byte_index,
    output logic       read_bus_word,
    output logic [3:0] word_index,
    output logic       clear_uP_packet,
    output logic       busy,
    output logic       error,
    output logic [1:0] error_code
);

    typedef enum logic [4:0] {
        S_IDLE, S_PING,
        S_RX0, S_RX1, S_RX2, S_RX3,
        S_DEC, S_CLR,
        S_WB0, S_WB1,
        S_RB0, S_RB1, S_RB2, S_RB3,
        S_TX0, S_TX1, S_TX2, S_TX3,
        S_DONE, S_ERR
    } state_t;

    localparam logic [7:0] IN_LAST  = 8'(IN_BYTES - 1);
    localparam logic [7:0] OUT_LAST = 8'(OUT_BYTES - 1);
    localparam logic [3:0] RX_LAST  = 4'(RX_WORDS - 1);

    state_t state;
    state_t nextState;

`ifdef UP_BRIDGE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] timer;
    logic          isWait;
    logic [1:0]    phaseCode;

    // Classify wait states and the phase each one reports on expiry
    always_comb begin
        isWait    = 1'b0;
        phaseCode = 2'd0;
        case (state)
            S_PING, S_RX0, S_RX2:        begin isWait = 1'b1; phaseCode = 2'd1; end
            S_WB0, S_WB1, S_RB0, S_RB2:  begin isWait = 1'b1; phaseCode = 2'd2; end
            S_TX1, S_TX2, S_DONE:        begin isWait = 1'b1; phaseCode = 2'd3; end
            default:                     begin isWait = 1'b0; phaseCode = 2'd0; end
        endcase
    end

    // Timeout counter: reload on every state change, count down while stalled
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer <= TW'(TIMEOUT_CYCLES);
        end else if (nextState != state) begin
            timer <= TW'(TIMEOUT_CYCLES);
        end else if (isWait && timer != '0) begin
            timer <= timer - 1'b1;
        end
    end

    // Sticky error flag, cleared when a new transaction starts
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            error      <= 1'b0;
            error_code <= 2'd0;
        end else if (state == S_IDLE && uP_start) begin
            error      <= 1'b0;
            error_code <= 2'd0;
        end else if (nextState == S_ERR && state != S_ERR) begin
            error      <= 1'b1;
            error_code <= phaseCode;
        end
    end
`else
    assign error      = 1'b0;
    assign error_code = 2'd0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic; an expired wait overrides staying put
    always_comb begin
        nextState = state;
        case (state)
            S_IDLE: begin
                if (uP_start)            nextState = S_RX0;
                else if (uP_handshake_1) nextState = S_PING;
            end
            S_PING:  if (!uP_handshake_1)  nextState = S_IDLE;
            S_RX0:   if (uP_handshake_1)   nextState = S_RX1;
            S_RX1:                         nextState = S_RX2;
            S_RX2:   if (!uP_handshake_1)  nextState = S_RX3;
            S_RX3:   nextState = (byte_index == IN_LAST) ? S_DEC : S_RX0;
            S_DEC:   nextState = uP_soft_reset ? S_CLR : S_WB0;
            S_CLR:                         nextState = S_TX0;
            S_WB0:   if (bus_handshake_2)  nextState = S_WB1;
            S_WB1:   if (!bus_handshake_2) nextState = S_RB0;
            S_RB0:   if (bus_handshake_2)  nextState = S_RB1;
            S_RB1:                         nextState = S_RB2;
            S_RB2:   if (!bus_handshake_2) nextState = S_RB3;
            S_RB3:   nextState = (word_index == RX_LAST) ? S_TX0 : S_RB0;
            S_TX0:                         nextState = S_TX1;
            S_TX1:   if (uP_handshake_1)   nextState = S_TX2;
            S_TX2:   if (!uP_handshake_1)  nextState = S_TX3;
            S_TX3:   nextState = (byte_index == OUT_LAST) ? S_DONE : S_TX0;
            S_DONE:  if (!uP_start)        nextState = S_IDLE;
            S_ERR:   if (!uP_start && !uP_handshake_1) nextState = S_IDLE;
            default:                       nextState = S_IDLE;
        endcase
`ifdef UP_BRIDGE_TIMEOUT_EN
        if (isWait && nextState == state && timer == '0) begin
            nextState = S_ERR;
        end
`endif
    end

    // Byte and word position counters; terminal compares stop them before wrap
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_index <= 8'd0;
            word_index <= 4'd0;
        end else begin
            case (state)
                S_IDLE: if (uP_start) byte_index <= 8'd0;
                S_RX3:  if (byte_index != IN_LAST) byte_index <= byte_index + 8'd1;
                S_DEC:  byte_index <= 8'd0;
                S_WB1:  if (!bus_handshake_2) word_index <= 4'd0;
                S_RB3: begin
                    if (word_index == RX_LAST) byte_index <= 8'd0;
                    else                       word_index <= word_index + 4'd1;
                end
                S_TX3:  if (byte_index != OUT_LAST) byte_index <= byte_index + 8'd1;
                default: ;
            endcase
        end
    end

    // Moore output decode
    always_comb begin
        uP_ack          = 1'b0;
        uP_handshake_2  = 1'b0;
        bus_handshake_1 = 1'b0;
        read_uP_byte    = 1'b0;
        write_uP_byte   = 1'b0;
        read_bus_word   = 1'b0;
        clear_uP_packet = 1'b0;
        busy            = (state != S_IDLE);
        case (state)
            S_PING, S_RX2, S_TX1: uP_handshake_2  = 1'b1;
            S_RX1:                read_uP_byte    = 1'b1;
            S_CLR:                clear_uP_packet = 1'b1;
            S_WB0, S_RB0:         bus_handshake_1 = 1'b1;
            S_RB1: begin
                bus_handshake_1 = 1'b1;
                read_bus_word   = 1'b1;
            end
            S_TX0:                write_uP_byte   = 1'b1;
            S_DONE:               uP_ack          = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_up_bus_bridge_fsm.sv
// Purpose: scoreboard bench for up_bus_bridge_fsm with reactive uP and bus-slave models.
// Latency: expected pulses are queued at transaction start and popped as the DUT produces them.
// Backpressure: the slave model can stall bus_handshake_2 to exercise timeout or indefinite waits.
module tb_up_bus_bridge_fsm;

    localparam int IN_B  = 8;
    localparam int OUT_B = 8;
    localparam int RX_W  = 2;
    localparam int TO    = 20;

    logic       clk;
    logic       reset;
    logic       uP_start;
    logic       uP_soft_reset;
    logic       uP_ack;
    logic       uP_handshake_1;
    logic       uP_handshake_2;
    logic       bus_handshake_1;
    logic       bus_handshake_2;
    logic       read_uP_byte;
    logic       write_uP_byte;
    logic [7:0] byte_index;
    logic       read_bus_word;
    logic [3:0] word_index;
    logic       clear_uP_packet;
    logic       busy;
    logic       error;
    logic [1:0] error_code;

    int testsRun  = 0;
    int failCount = 0;

    logic [15:0] expQ[$];

    bit finished;
    int hb1Cycle;
    int errCycle;
    int busCycles;

    up_bus_bridge_fsm #(
        .IN_BYTES(IN_B), .OUT_BYTES(OUT_B), .RX_WORDS(RX_W), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .uP_start(uP_start), .uP_soft_reset(uP_soft_reset), .uP_ack(uP_ack),
        .uP_handshake_1(uP_handshake_1), .uP_handshake_2(uP_handshake_2),
        .bus_handshake_1(bus_handshake_1), .bus_handshake_2(bus_handshake_2),
        .read_uP_byte(read_uP_byte), .write_uP_byte(write_uP_byte),
        .byte_index(byte_index), .read_bus_word(read_bus_word),
        .word_index(word_index), .clear_uP_packet(clear_uP_packet),
        .busy(busy), .error(error), .error_code(error_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        if (obs !== exp) begin
            failCount++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic scoreCheck(input string tag, input logic [15:0] obs);
        logic [15:0] exp;
        if (expQ.size() == 0) exp = 16'hFFFF;
        else                  exp = expQ.pop_front();
        checkEq(tag, {16'h0, obs}, {16'h0, exp});
    endtask

    function automatic logic [22:0] allOutputs();
        return {uP_ack, uP_handshake_2, bus_handshake_1, read_uP_byte, write_uP_byte,
                read_bus_word, clear_uP_packet, busy, error, error_code, byte_index, word_index};
    endfunction

    // Drives one transaction with reactive uP / slave models until ack+idle, error, abort or budget.
    task automatic runTransaction(input bit softRst, input bit stall, input bit abortTx, input int budget);
        int  cyc     = 0;
        int  rxSent  = 0;
        bit  ackSeen = 0;
        bit  prevAck = 0;
        finished  = 0;
        hb1Cycle  = -1;
        errCycle  = -1;
        busCycles = 0;
        for (int i = 0; i < IN_B; i++) expQ.push_back({8'h01, 8'(i)});
        if (!stall) begin
            if (softRst) expQ.push_back(16'h0500);
            else for (int w = 0; w < RX_W; w++) expQ.push_back({8'h02, 8'(w)});
            for (int i = 0; i < OUT_B; i++) expQ.push_back({8'h03, 8'(i)});
            expQ.push_back(16'h0400);
        end
        uP_soft_reset = softRst;
        uP_start      = 1'b1;
        while (cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (read_uP_byte)    scoreCheck("rd_byte", {8'h01, byte_index});
            if (read_bus_word)   scoreCheck("rd_word", {8'h02, 4'h0, word_index});
            if (write_uP_byte)   scoreCheck("wr_byte", {8'h03, byte_index});
            if (clear_uP_packet) scoreCheck("clear", 16'h0500);
            if (uP_ack && !prevAck) scoreCheck("ack", 16'h0400);
            prevAck = uP_ack;
            if (bus_handshake_1) begin
                busCycles++;
                if (hb1Cycle < 0) hb1Cycle = cyc;
            end
            if (uP_ack) begin
                ackSeen  = 1;
                uP_start = 1'b0;
            end
            if (ackSeen && !busy) begin
                finished = 1;
                break;
            end
            if (error) begin
                errCycle = cyc;
                break;
            end
            if (abortTx && rxSent == IN_B && uP_handshake_2) begin
                reset = 1'b0;
                #1;
                checkEq("rst_outputs", {9'h0, allOutputs()}, 32'h0);
                checkEq("rst_busy", {31'h0, busy}, 32'h0);
                uP_start        = 1'b0;
                uP_handshake_1  = 1'b0;
                bus_handshake_2 = 1'b0;
                @(negedge clk);
                reset = 1'b1;
                expQ.delete();
                break;
            end
            bus_handshake_2 = stall ? 1'b0 : bus_handshake_1;
            if (rxSent < IN_B) begin
                if (uP_handshake_2) begin
                    if (uP_handshake_1) rxSent++;
                    uP_handshake_1 = 1'b0;
                end else begin
                    uP_handshake_1 = 1'b1;
                end
            end else begin
                uP_handshake_1 = uP_handshake_2;
            end
        end
    endtask

    initial begin
        bit pingHs2;
        bit pingAck;
        reset           = 1'b0;
        uP_start        = 1'b0;
        uP_soft_reset   = 1'b0;
        uP_handshake_1  = 1'b0;
        bus_handshake_2 = 1'b0;
        #2;
        checkEq("reset_outputs", {9'h0, allOutputs()}, 32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Normal transaction
        runTransaction(0, 0, 0, 2000);
        checkEq("normal_done", {31'h0, finished}, 32'd1);
        checkEq("normal_queue", expQ.size(), 32'd0);
        checkEq("normal_error", {31'h0, error}, 32'd0);

        // Soft reset: clear pulse, no bus activity
        runTransaction(1, 0, 0, 2000);
        checkEq("soft_done", {31'h0, finished}, 32'd1);
        checkEq("soft_queue", expQ.size(), 32'd0);
        checkEq("soft_bus_idle", busCycles, 32'd0);
        uP_soft_reset = 1'b0;

        // Ping
        pingHs2 = 0;
        pingAck = 0;
        uP_handshake_1 = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (uP_handshake_2) pingHs2 = 1;
            if (uP_ack) pingAck = 1;
        end
        checkEq("ping_busy", {31'h0, busy}, 32'd1);
        uP_handshake_1 = 1'b0;
        @(negedge clk);
        checkEq("ping_hs2_seen", {31'h0, pingHs2}, 32'd1);
        checkEq("ping_ack", {31'h0, pingAck}, 32'd0);
        checkEq("ping_idle", {30'h0, busy, uP_handshake_2}, 32'd0);

`ifdef UP_BRIDGE_TIMEOUT_EN
        // Bus stall with timeout
        runTransaction(0, 1, 0, 400);
        checkEq("to_reached", {31'h0, (errCycle >= 0)}, 32'd1);
        checkEq("to_latency", errCycle - hb1Cycle, 32'd21);
        checkEq("to_code", {30'h0, error_code}, 32'd2);
        checkEq("to_strobes", {30'h0, bus_handshake_1, uP_handshake_2}, 32'd0);
        uP_start        = 1'b0;
        bus_handshake_2 = 1'b0;
        repeat (2) @(negedge clk);
        checkEq("err_idle", {31'h0, busy}, 32'd0);
        checkEq("err_sticky", {31'h0, error}, 32'd1);
        expQ.delete();
        runTransaction(0, 0, 0, 2000);
        checkEq("post_err_done", {31'h0, finished}, 32'd1);
        checkEq("post_err_clear", {29'h0, error, error_code}, 32'd0);
`else
        // Bus stall without timeout: waits forever
        runTransaction(0, 1, 0, 1000);
        checkEq("stall_not_done", {31'h0, finished}, 32'd0);
        checkEq("stall_hb1", {31'h0, bus_handshake_1}, 32'd1);
        checkEq("stall_hb1_held", {31'h0, (busCycles >= 900)}, 32'd1);
        checkEq("stall_error", {29'h0, error, error_code}, 32'd0);
        reset           = 1'b0;
        uP_start        = 1'b0;
        uP_handshake_1  = 1'b0;
        bus_handshake_2 = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        expQ.delete();
        @(negedge clk);
`endif

        // Reset during S_TX1, then a clean transaction
        runTransaction(0, 0, 1, 2000);
        @(negedge clk);
        runTransaction(0, 0, 0, 2000);
        checkEq("after_rst_done", {31'h0, finished}, 32'd1);
        checkEq("after_rst_queue", expQ.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
